// File: rtl/snake_food_placer.sv
// snake_food_placer: sequences the random-coordinate LFSR, folds each sample
// into the play grid, checks it against the snake body and reports the
// chosen food cell (or a failure) to the game FSM and renderer.
// Optional feature: define SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN to add a
// linear raster scan of the grid after MAX_TRIES random candidates all hit.

module snake_food_placer #(
  parameter int unsigned GRID_W    = 40,
  parameter int unsigned GRID_H    = 30,
  parameter int unsigned X_W       = 6,
  parameter int unsigned Y_W       = 5,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic           clk1,
  input  logic           rst_n,
  input  logic           place_req,
  input  logic [9:0]     rnd_x,
  input  logic [9:0]     rnd_y,
  output logic           lfsr_step,
  output logic           occ_req,
  output logic [X_W-1:0] occ_x,
  output logic [Y_W-1:0] occ_y,
  input  logic           occ_ack,
  input  logic           occ_hit,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           food_valid,
  output logic           place_fail,
  output logic           busy
);

  localparam int unsigned TRY_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP   = 3'd1,
    S_SAMPLE = 3'd2,
    S_QUERY  = 3'd3,
    S_DONE   = 3'd4
`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
    ,
    S_SCAN   = 3'd5
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             lfsr_step_q, lfsr_step_d;
  logic             occ_req_q, occ_req_d;
  logic [X_W-1:0]   occ_x_q, occ_x_d;
  logic [Y_W-1:0]   occ_y_q, occ_y_d;
  logic [X_W-1:0]   food_x_q, food_x_d;
  logic [Y_W-1:0]   food_y_q, food_y_d;
  logic             food_valid_q, food_valid_d;
  logic             place_fail_q, place_fail_d;
  logic             busy_q, busy_d;
  logic             more_tries;

  // Only the low coordinate bits of the LFSR words are meaningful here.
  logic unused_rnd;
  assign unused_rnd = &{1'b0, rnd_x[9:X_W], rnd_y[9:Y_W]};

  // Single conditional subtract folds a raw coordinate into [0, GRID_W).
  function automatic logic [X_W-1:0] fold_x(input logic [X_W-1:0] v);
    logic [X_W:0] wide;
    wide = {1'b0, v};
    if (wide >= (X_W+1)'(GRID_W)) begin
      fold_x = X_W'(wide - (X_W+1)'(GRID_W));
    end else begin
      fold_x = v;
    end
  endfunction

  // Single conditional subtract folds a raw coordinate into [0, GRID_H).
  function automatic logic [Y_W-1:0] fold_y(input logic [Y_W-1:0] v);
    logic [Y_W:0] wide;
    wide = {1'b0, v};
    if (wide >= (Y_W+1)'(GRID_H)) begin
      fold_y = Y_W'(wide - (Y_W+1)'(GRID_H));
    end else begin
      fold_y = v;
    end
  endfunction

  // True while the random-retry budget is not yet used up after this hit.
  assign more_tries = ({1'b0, tries_q} + 9'd1) < 9'(MAX_TRIES);

`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
  localparam int unsigned CELLS  = GRID_W * GRID_H;
  localparam int unsigned SCAN_W = $clog2(CELLS + 1);

  logic [X_W-1:0]    adv_x;
  logic [Y_W-1:0]    adv_y;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;

  // Next cell in raster order from the current query, wrapping at the edges.
  always_comb begin
    adv_x = occ_x_q + X_W'(1);
    adv_y = occ_y_q;
    if (occ_x_q == X_W'(GRID_W - 1)) begin
      adv_x = '0;
      if (occ_y_q == Y_W'(GRID_H - 1)) begin
        adv_y = '0;
      end else begin
        adv_y = occ_y_q + Y_W'(1);
      end
    end
  end
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    lfsr_step_d  = 1'b0;
    occ_req_d    = occ_req_q;
    occ_x_d      = occ_x_q;
    occ_y_d      = occ_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = 1'b0;
    place_fail_d = 1'b0;
`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
    scan_cnt_d   = scan_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (place_req) begin
          tries_d     = '0;
          lfsr_step_d = 1'b1;
          state_d     = S_STEP;
        end
      end

      S_STEP: begin
        state_d = S_SAMPLE;
      end

      S_SAMPLE: begin
        occ_x_d   = fold_x(rnd_x[X_W-1:0]);
        occ_y_d   = fold_y(rnd_y[Y_W-1:0]);
        occ_req_d = 1'b1;
        state_d   = S_QUERY;
      end

      S_QUERY: begin
        if (occ_ack) begin
          occ_req_d = 1'b0;
          if (!occ_hit) begin
            food_x_d     = occ_x_q;
            food_y_d     = occ_y_q;
            food_valid_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            tries_d = tries_q + TRY_W'(1);
            if (more_tries) begin
              lfsr_step_d = 1'b1;
              state_d     = S_STEP;
            end else begin
`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
              occ_x_d    = adv_x;
              occ_y_d    = adv_y;
              scan_cnt_d = SCAN_W'(1);
              state_d    = S_SCAN;
`else
              place_fail_d = 1'b1;
              state_d      = S_DONE;
`endif
            end
          end
        end
      end

`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
      // occ_req idles low for one cycle between scan queries.
      S_SCAN: begin
        if (!occ_req_q) begin
          occ_req_d = 1'b1;
        end else if (occ_ack) begin
          occ_req_d = 1'b0;
          if (!occ_hit) begin
            food_x_d     = occ_x_q;
            food_y_d     = occ_y_q;
            food_valid_d = 1'b1;
            state_d      = S_DONE;
          end else if (scan_cnt_q == SCAN_W'(CELLS)) begin
            place_fail_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            occ_x_d    = adv_x;
            occ_y_d    = adv_y;
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
          end
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        occ_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tries_q      <= '0;
      lfsr_step_q  <= 1'b0;
      occ_req_q    <= 1'b0;
      occ_x_q      <= '0;
      occ_y_q      <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      place_fail_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
      scan_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      lfsr_step_q  <= lfsr_step_d;
      occ_req_q    <= occ_req_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      place_fail_q <= place_fail_d;
      busy_q       <= busy_d;
`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
      scan_cnt_q   <= scan_cnt_d;
`endif
    end
  end

  assign lfsr_step  = lfsr_step_q;
  assign occ_req    = occ_req_q;
  assign occ_x      = occ_x_q;
  assign occ_y      = occ_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign place_fail = place_fail_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_snake_food_placer.sv
// Bench for snake_food_placer: folding vector table, directed retry /
// exhaustion / reset / busy sequences, and randomized placements checked
// against a grid-level reference model.

module tb_snake_food_placer;

  localparam int GW    = 40;
  localparam int GH    = 30;
  localparam int XW    = 6;
  localparam int YW    = 5;
  localparam int MT    = 16;
  localparam int CELLS = GW * GH;

  logic          clk1 = 1'b0;
  logic          rst_n;
  logic          place_req;
  logic [9:0]    rnd_x, rnd_y;
  logic          lfsr_step, occ_req, occ_ack, occ_hit;
  logic [XW-1:0] occ_x, food_x;
  logic [YW-1:0] occ_y, food_y;
  logic          food_valid, place_fail, busy;

  snake_food_placer #(
    .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .MAX_TRIES(MT)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .place_req(place_req),
    .rnd_x(rnd_x), .rnd_y(rnd_y), .lfsr_step(lfsr_step),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .place_fail(place_fail), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  // Environment state shared by the helper processes.
  bit occ_grid [0:GW-1][0:GH-1];
  int cand_rx [0:MT-1];
  int cand_ry [0:MT-1];
  int step_ptr = 0;
  int lat = 0;
  bit manual_mode = 0;
  int t0 = 0;
  int n_step, n_req, n_valid, n_fail, n_query;
  int first_step, first_req, first_valid;
  int bad_cell = 0, stable_err = 0, proto_err = 0;
  int qx[$];
  int qy[$];

  // Reference model state: predicted outcome of the current placement.
  bit exp_ok;
  int exp_steps, exp_queries;
  int exp_fx = 0, exp_fy = 0;

  typedef struct {
    logic [9:0] rx;
    logic [9:0] ry;
    int         ex;
    int         ey;
  } vec_t;
  vec_t tbl [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // LFSR stand-in: each lfsr_step pulse presents the next candidate word.
  initial begin
    bit s;
    rnd_x = '0;
    rnd_y = '0;
    forever begin
      @(negedge clk1);
      s = lfsr_step;
      @(posedge clk1);
      #1;
      if (s) begin
        if (step_ptr < MT) begin
          rnd_x = 10'(cand_rx[step_ptr]);
          rnd_y = 10'(cand_ry[step_ptr]);
        end else begin
          rnd_x = 10'($urandom);
          rnd_y = 10'($urandom);
        end
        step_ptr++;
      end
    end
  end

  // Snake-body store stand-in: answers from occ_grid after lat wait cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    occ_ack = 1'b0;
    occ_hit = 1'b0;
    forever begin
      @(negedge clk1);
      #1;
      if (!manual_mode) begin
        if (occ_req && !occ_ack) begin
          if (wcnt >= lat) begin
            occ_ack = 1'b1;
            if (int'(occ_x) < GW && int'(occ_y) < GH) begin
              occ_hit = occ_grid[occ_x][occ_y];
            end else begin
              occ_hit = 1'b1;
              bad_cell++;
            end
            qx.push_back(int'(occ_x));
            qy.push_back(int'(occ_y));
            n_query++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          occ_ack = 1'b0;
          occ_hit = 1'b0;
          wcnt = 0;
        end
      end
    end
  end

  // Output monitor: pulse counts, first-event latencies, handshake rules.
  initial begin
    bit prev_req;
    int px, py;
    prev_req = 1'b0;
    px = 0;
    py = 0;
    forever begin
      @(negedge clk1);
      if (rst_n) begin
        if (lfsr_step) begin
          n_step++;
          if (first_step < 0) first_step = cyc - t0;
        end
        if (occ_req && !prev_req) begin
          n_req++;
          if (first_req < 0) first_req = cyc - t0;
        end
        if (occ_req && prev_req && (int'(occ_x) != px || int'(occ_y) != py)) stable_err++;
        if (occ_ack && prev_req && occ_req) proto_err++;
        if (food_valid) begin
          n_valid++;
          if (first_valid < 0) first_valid = cyc - t0;
        end
        if (place_fail) n_fail++;
      end
      prev_req = occ_req;
      px = int'(occ_x);
      py = int'(occ_y);
    end
  end

  task automatic clear_counts();
    n_step = 0; n_req = 0; n_valid = 0; n_fail = 0; n_query = 0;
    first_step = -1; first_req = -1; first_valid = -1;
    qx.delete();
    qy.delete();
  endtask

  task automatic fill_grid(input int pct);
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++)
        occ_grid[x][y] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic rand_cands();
    for (int i = 0; i < MT; i++) begin
      cand_rx[i] = int'($urandom_range(0, 1023));
      cand_ry[i] = int'($urandom_range(0, 1023));
    end
  endtask

  // Grid-level model: first free random candidate, else optional raster scan.
  function automatic void predict();
    int cx, cy, lin;
    exp_ok = 0; exp_steps = 0; exp_queries = 0;
    cx = 0; cy = 0;
    for (int i = 0; i < MT; i++) begin
      cx = (cand_rx[i] % 64) % GW;
      cy = (cand_ry[i] % 32) % GH;
      exp_steps++;
      exp_queries++;
      if (!occ_grid[cx][cy]) begin
        exp_ok = 1; exp_fx = cx; exp_fy = cy;
        return;
      end
    end
`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
    lin = cy * GW + cx;
    for (int k = 1; k <= CELLS; k++) begin
      int idx;
      idx = (lin + k) % CELLS;
      exp_queries++;
      if (!occ_grid[idx % GW][idx / GW]) begin
        exp_ok = 1; exp_fx = idx % GW; exp_fy = idx / GW;
        return;
      end
    end
`else
    lin = 0;
`endif
  endfunction

  task automatic start_place();
    step_ptr = 0;
    clear_counts();
    @(posedge clk1);
    #1;
    place_req = 1'b1;
    t0 = cyc;
    @(posedge clk1);
    #1;
    place_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit spam);
    int k;
    k = 0;
    while (n_valid + n_fail == 0 && k < budget) begin
      @(posedge clk1);
      #1;
      place_req = (spam && busy) ? ~place_req : 1'b0;
      k++;
    end
    place_req = 1'b0;
    check({name, "_done_in_budget"}, 32'(k < budget), 32'd1);
    repeat (2) begin
      @(posedge clk1);
      #1;
    end
  endtask

  // Runs one placement and compares it with the model's prediction.
  task automatic run_checked(input string name, input int budget);
    predict();
    start_place();
    wait_done(name, budget, 1'b0);
    check({name, "_ok"}, 32'(n_valid), 32'(exp_ok));
    check({name, "_fail"}, 32'(n_fail), 32'(!exp_ok));
    check({name, "_steps"}, 32'(n_step), 32'(exp_steps));
    check({name, "_queries"}, 32'(n_query), 32'(exp_queries));
    check({name, "_food"}, {16'(food_x), 16'(food_y)}, {16'(exp_fx), 16'(exp_fy)});
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({lfsr_step, occ_req, occ_x, occ_y, food_x, food_y, food_valid, place_fail, busy});
  endfunction

  initial begin
    int k;
    bit found;
    rst_n = 1'b0;
    place_req = 1'b0;
    fill_grid(0);
    rand_cands();
    clear_counts();

    tbl[0] = '{10'h000, 10'h000, 0, 0};
    tbl[1] = '{10'h03F, 10'h01F, 23, 1};
    tbl[2] = '{10'h027, 10'h01D, 39, 29};
    tbl[3] = '{10'h028, 10'h01E, 0, 0};
    tbl[4] = '{10'h3FF, 10'h3FF, 23, 1};
    tbl[5] = '{10'h140, 10'h3E0, 0, 0};
    tbl[6] = '{10'h22D, 10'h1F4, 5, 20};
    tbl[7] = '{10'h011, 10'h00C, 17, 12};

    repeat (3) @(posedge clk1);
    #1;
    check("reset_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    check("idle_after_reset", 32'(busy), 32'd0);

    // Folding vectors on an empty grid, same-cycle acknowledge.
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      cand_rx[0] = int'(tbl[i].rx);
      cand_ry[0] = int'(tbl[i].ry);
      start_place();
      wait_done($sformatf("vec%0d", i), 40, 1'b0);
      check($sformatf("vec%0d_food", i), {16'(food_x), 16'(food_y)},
            {16'(tbl[i].ex), 16'(tbl[i].ey)});
      check($sformatf("vec%0d_latency", i),
            32'(first_step * 100 + first_req * 10 + first_valid), 32'd134);
      exp_fx = tbl[i].ex;
      exp_fy = tbl[i].ey;
    end

    // Two hits then a free cell, with one wait cycle per answer.
    lat = 1;
    fill_grid(0);
    occ_grid[5][5] = 1'b1;
    occ_grid[6][6] = 1'b1;
    cand_rx[0] = 5; cand_ry[0] = 5;
    cand_rx[1] = 6; cand_ry[1] = 6;
    cand_rx[2] = 7; cand_ry[2] = 7;
    start_place();
    wait_done("retry", 60, 1'b0);
    check("retry_steps", 32'(n_step), 32'd3);
    check("retry_reqs", 32'(n_req), 32'd3);
    check("retry_valid", 32'(n_valid), 32'd1);
    check("retry_food", {16'(food_x), 16'(food_y)}, {16'd7, 16'd7});
    exp_fx = 7; exp_fy = 7;

    // Same scenario with place_req toggling throughout the busy period.
    start_place();
    wait_done("busy_spam", 60, 1'b1);
    check("busy_spam_steps", 32'(n_step), 32'd3);
    check("busy_spam_valid", 32'(n_valid), 32'd1);
    check("busy_spam_idle", 32'(busy), 32'd0);

    // A request in the first IDLE cycle after DONE is accepted.
    lat = 0;
    fill_grid(0);
    cand_rx[0] = 12; cand_ry[0] = 3;
    start_place();
    k = 0;
    while (!food_valid && k < 40) begin
      @(negedge clk1);
      k++;
    end
    check("first_done_seen", 32'(food_valid), 32'd1);
    @(posedge clk1);
    #1;
    check("back_to_idle", 32'(busy), 32'd0);
    step_ptr = 0;
    cand_rx[0] = 20; cand_ry[0] = 9;
    place_req = 1'b1;
    @(posedge clk1);
    #1;
    place_req = 1'b0;
    clear_counts();
    check("reaccept_busy", 32'({busy, lfsr_step}), 32'b11);
    wait_done("reaccept", 40, 1'b0);
    check("reaccept_food", {16'(food_x), 16'(food_y)}, {16'd20, 16'd9});
    exp_fx = 20; exp_fy = 9;

    // Every cell occupied.
    fill_grid(100);
    rand_cands();
    lat = 0;
    run_checked("exhaust", 6000);

`ifdef SNAKE_FOOD_PLACER_LINEAR_FALLBACK_EN
    // Only (0,0) free; last candidate (37,4) forces a long wrapping scan.
    fill_grid(100);
    occ_grid[0][0] = 1'b0;
    for (int i = 0; i < MT; i++) begin
      cand_rx[i] = 37; cand_ry[i] = 4;
    end
    run_checked("scan_origin", 6000);
    found = 1'b0;
    for (int j = 0; j + 1 < qx.size(); j++)
      if (qx[j] == GW - 1 && qx[j+1] == 0 && qy[j+1] == (qy[j] + 1) % GH) found = 1'b1;
    check("scan_row_wrap", 32'(found), 32'd1);
`else
    found = 1'b0;
`endif

    // Randomized placements with random density and answer latency.
    for (int r = 0; r < 25; r++) begin
      lat = int'($urandom_range(0, 3));
      fill_grid(int'($urandom_range(0, 90)));
      rand_cands();
      run_checked($sformatf("rand%0d", r), 4000);
    end

    // Reset while a query is outstanding; a late answer must be ignored.
    lat = 1000;
    fill_grid(0);
    rand_cands();
    start_place();
    k = 0;
    while (!occ_req && k < 20) begin
      @(posedge clk1);
      #1;
      k++;
    end
    check("query_reached", 32'(occ_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_query_reset", out_vec(), 32'd0);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
    manual_mode = 1'b1;
    clear_counts();
    @(negedge clk1);
    #1;
    occ_ack = 1'b1;
    occ_hit = 1'b0;
    @(negedge clk1);
    #1;
    occ_ack = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    check("late_ack_ignored", 32'({n_valid[7:0], n_fail[7:0], 7'(0), busy}), 32'd0);
    check("food_after_reset", {16'(food_x), 16'(food_y)}, 32'd0);
    manual_mode = 1'b0;
    exp_fx = 0; exp_fy = 0;

    check("no_bad_cell", 32'(bad_cell), 32'd0);
    check("occ_stable", 32'(stable_err), 32'd0);
    check("req_drops_after_ack", 32'(proto_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
